dmem_bus_arbiter: RTL and testbench

//  Shares the MCU data bus (data_memory + chu_uart MMIO window) between two requesters:
//  M0 = risc_v_core data port, M1 = auxiliary master (UART boot loader / debug DMA).

---
 rtl/dmem_bus_arbiter_if.sv | 58 +++++
 rtl/dmem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// ============================================================================
// dmem_bus_arbiter_if : two-master data-bus bundle (requesters + RAM/UART side)
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_bus_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             m0_req;
    logic             m0_we;
    logic             m0_lock;
    logic [WIDTH-1:0] m0_addr;
    logic [WIDTH-1:0] m0_wdata;
    logic             m0_gnt;
    logic             m0_rvalid;
    logic [WIDTH-1:0] m0_rdata;

    logic             m1_req;
    logic             m1_we;
    logic             m1_lock;
    logic [WIDTH-1:0] m1_addr;
    logic [WIDTH-1:0] m1_wdata;
    logic             m1_gnt;
    logic             m1_rvalid;
    logic [WIDTH-1:0] m1_rdata;

    logic [WIDTH-1:0] bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic             ram_we;
    logic             uart_cs;
    logic             uart_wr;
    logic             uart_rd;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] uart_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  ram_rdata, uart_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bus_addr, bus_wdata, ram_we, uart_cs, uart_wr, uart_rd
    );

    // Environment side: requesters plus the RAM/UART models
    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output ram_rdata, uart_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bus_addr, bus_wdata, ram_we, uart_cs, uart_wr, uart_rd
    );
endinterface

`default_nettype wire

// File: rtl/dmem_bus_arbiter.sv
// ============================================================================
// dmem_bus_arbiter : round-robin, burst-lockable arbiter for the MCU data bus
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_bus_arbiter #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] UART_D_S_R = WIDTH'(32'h0000_0500),
    parameter logic [WIDTH-1:0] UART_B     = WIDTH'(32'h0000_0501),
    parameter logic [WIDTH-1:0] UART_W_D   = WIDTH'(32'h0000_0502),
    parameter logic [WIDTH-1:0] UART_DUMB  = WIDTH'(32'h0000_0503),
    parameter int               MAX_BURST  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_bus_arbiter_if.slave bus
);

    localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic               win;
    logic               sel;
    logic               sel_req;
    logic               sel_lock;
    logic               sel_we;
    logic [WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic               access;
    logic               uart_wr_addr;
    logic               uart_wr;
    logic               uart_rd;

    // On a tie the master that did not own the bus last time wins
    always_comb begin
        win = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            win = ~last_owner_q;
        end
    end

    // In IDLE the command comes from the winner; in RESP from the current owner
    assign sel       = (state_q == S_IDLE) ? win : owner_q;
    assign sel_req   = sel ? bus.m1_req   : bus.m0_req;
    assign sel_lock  = sel ? bus.m1_lock  : bus.m0_lock;
    assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    owner_d     = win;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    burst_cnt_d = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = (addr_q == UART_D_S_R) ? bus.uart_rdata : bus.ram_rdata;
                state_d = S_RESP;
            end
            S_RESP: begin
                last_owner_d = owner_q;
                if (sel_req && sel_lock && (burst_cnt_q < BURST_LAST)) begin
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    state_d     = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Writes to the UART status register hit neither RAM nor UART
    assign access       = (state_q == S_ACCESS);
    assign uart_wr_addr = (addr_q == UART_B) || (addr_q == UART_W_D) || (addr_q == UART_DUMB);
    assign uart_wr      = access & we_q & uart_wr_addr;
    assign uart_rd      = access & ~we_q & (addr_q == UART_D_S_R);

    assign bus.uart_wr   = uart_wr;
    assign bus.uart_rd   = uart_rd;
    assign bus.uart_cs   = uart_wr | uart_rd;
    assign bus.ram_we    = access & we_q & ~uart_wr_addr & (addr_q != UART_D_S_R);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign bus.m0_gnt    = access & ~owner_q;
    assign bus.m1_gnt    = access & owner_q;
    assign bus.m0_rvalid = (state_q == S_RESP) & ~owner_q;
    assign bus.m1_rvalid = (state_q == S_RESP) & owner_q;
    assign bus.m0_rdata  = rdata_q;
    assign bus.m1_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
// ============================================================================
// tb_dmem_bus_arbiter : directed bench with a transaction-schedule reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bus_arbiter;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_bus_arbiter_if #(.WIDTH(WIDTH)) bus ();

    dmem_bus_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    logic [31:0] env_mem   [256];
    logic [31:0] model_mem [256];
    logic [31:0] uart_val;

    assign bus.ram_rdata  = env_mem[bus.bus_addr[7:0]];
    assign bus.uart_rdata = uart_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one transaction in flight, scheduled by cycle number
    int          t_gnt    = -10;
    int          t_rsp    = -10;
    logic        t_own    = 1'b0;
    logic        t_we     = 1'b0;
    logic [31:0] t_addr   = '0;
    logic [31:0] t_wdata  = '0;
    logic        last_own = 1'b1;
    int          burst    = 0;
    logic [31:0] e_addr   = '0;
    logic [31:0] e_wdata  = '0;
    logic [31:0] e_rdata  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // {ram_we, uart_cs, uart_wr, uart_rd} for a command
    function automatic logic [3:0] decode(input logic we, input logic [31:0] a);
        if (we && (a == 32'h501 || a == 32'h502 || a == 32'h503)) return 4'b0110;
        if (!we && a == 32'h500) return 4'b0101;
        if (we && a != 32'h500) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic void take(input logic o);
        t_own   = o;
        t_we    = o ? bus.m1_we    : bus.m0_we;
        t_addr  = o ? bus.m1_addr  : bus.m0_addr;
        t_wdata = o ? bus.m1_wdata : bus.m0_wdata;
        t_gnt   = cyc + 1;
        t_rsp   = cyc + 2;
        e_addr  = t_addr;
        e_wdata = t_wdata;
    endfunction

    initial begin
        logic [3:0] st;
        logic       oreq, olock;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            env_mem[i]  <= '0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                t_gnt = -10; t_rsp = -10; last_own = 1'b1; burst = 0;
                e_addr = '0; e_wdata = '0; e_rdata = '0;
            end else begin
                if (cyc == t_gnt) begin
                    e_rdata = (t_addr == 32'h500) ? uart_val : model_mem[t_addr[7:0]];
                    st = decode(t_we, t_addr);
                    if (st[3]) model_mem[t_addr[7:0]] = t_wdata;
                end
                if (cyc == t_rsp) begin
                    last_own = t_own;
                    oreq  = t_own ? bus.m1_req  : bus.m0_req;
                    olock = t_own ? bus.m1_lock : bus.m0_lock;
                    if (oreq && olock && burst < MAX_BURST - 1) begin
                        burst++;
                        take(t_own);
                    end
                end else if (cyc > t_rsp && (bus.m0_req || bus.m1_req)) begin
                    burst = 0;
                    take((bus.m0_req && bus.m1_req) ? ~last_own : bus.m1_req);
                end
            end
            if (bus.ram_we) env_mem[bus.bus_addr[7:0]] <= bus.bus_wdata;
            cyc++;
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [3:0] st;
        logic [7:0] exp_ctl, act_ctl;
        forever begin
            @(negedge clk);
            st = (cyc == t_gnt) ? decode(t_we, t_addr) : 4'b0000;
            exp_ctl = {cyc == t_gnt && !t_own, cyc == t_gnt && t_own,
                       cyc == t_rsp && !t_own, cyc == t_rsp && t_own, st};
            act_ctl = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                       bus.ram_we, bus.uart_cs, bus.uart_wr, bus.uart_rd};
            check("ctl", {24'd0, act_ctl}, {24'd0, exp_ctl});
            check("bus_addr", bus.bus_addr, e_addr);
            check("bus_wdata", bus.bus_wdata, e_wdata);
            check("m0_rdata", bus.m0_rdata, e_rdata);
            check("m1_rdata", bus.m1_rdata, e_rdata);
        end
    end

    task automatic set_m(input int m, input logic req, input logic we, input logic lock,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? bus.m0_gnt : bus.m1_gnt;
    endfunction

    function automatic logic rvalid_of(input int m);
        return (m == 0) ? bus.m0_rvalid : bus.m1_rvalid;
    endfunction

    // Issues n back-to-back commands (address +4, data +1 each); entered and left just after a rising edge
    task automatic drive(input int m, input int n, input logic we, input logic lock,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lg, output int lr,
                         output logic [3:0] strb, output logic [31:0] ga);
        int start, k;
        start = cyc; lg = -1; lr = -1; rd = '0; strb = '0; ga = '0;
        set_m(m, 1'b1, we, lock, a, d);
        for (int i = 0; i < n; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!gnt_of(m) && k < 60);
            if (!gnt_of(m)) begin
                checks++; errors++;
                $display("FAIL gnt_timeout m%0d txn=%0d actual=0 required=1", m, i);
                set_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
                @(posedge clk); #1;
                return;
            end
            if (i == 0) begin
                lg   = cyc - start;
                strb = {bus.ram_we, bus.uart_cs, bus.uart_wr, bus.uart_rd};
                ga   = bus.bus_addr;
            end
            @(posedge clk); #1;
            if (i < n - 1) set_m(m, 1'b1, we, lock, a + 32'(4 * (i + 1)), d + 32'(i + 1));
            else           set_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            check("rvalid_after_gnt", {31'd0, rvalid_of(m)}, 32'd1);
            if (i == 0) lr = cyc - start;
            rd = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd0, rd1, ga0, ga1;
        int          lg0, lr0, lg1, lr1, k;
        logic [3:0]  s0, s1;

        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        uart_val = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_ctl", {24'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                            bus.ram_we, bus.uart_cs, bus.uart_wr, bus.uart_rd}, 32'd0);
        check("reset_bus_addr", bus.bus_addr, 32'd0);
        check("reset_rdata", bus.m0_rdata, 32'd0);
        @(posedge clk); #1;

        // RAM write then read-back
        drive(0, 1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd0, lg0, lr0, s0, ga0);
        check("t1_gnt_latency", 32'(lg0), 32'd1);
        check("t1_rvalid_latency", 32'(lr0), 32'd2);
        check("t1_write_strobes", {28'd0, s0}, 32'h8);
        drive(0, 1, 1'b0, 1'b0, 32'h10, 32'h0, rd0, lg0, lr0, s0, ga0);
        check("t1_read_data", rd0, 32'hDEADBEEF);
        check("t1_read_strobes", {28'd0, s0}, 32'h0);

        // UART write-data register from M1
        drive(1, 1, 1'b1, 1'b0, 32'h502, 32'h41, rd1, lg1, lr1, s1, ga1);
        check("t3_uart_wr_strobes", {28'd0, s1}, 32'h6);
        check("t3_bus_addr_lsbs", {30'd0, ga1[1:0]}, 32'd2);

        // UART status read and a dropped write to it
        uart_val = 32'h1FF;
        drive(0, 1, 1'b0, 1'b0, 32'h500, 32'h0, rd0, lg0, lr0, s0, ga0);
        check("t4_uart_rd_strobes", {28'd0, s0}, 32'h5);
        check("t4_uart_rdata", rd0, 32'h1FF);
        drive(0, 1, 1'b1, 1'b0, 32'h500, 32'h77, rd0, lg0, lr0, s0, ga0);
        check("t4_dropped_write_strobes", {28'd0, s0}, 32'h0);

        // Simultaneous requests straight out of reset
        do_reset();
        fork
            drive(0, 2, 1'b1, 1'b0, 32'h20, 32'hA0, rd0, lg0, lr0, s0, ga0);
            drive(1, 2, 1'b1, 1'b0, 32'h40, 32'hB0, rd1, lg1, lr1, s1, ga1);
        join
        check("t2_m0_first_gnt", 32'(lg0), 32'd1);
        check("t2_m1_first_gnt", 32'(lg1), 32'd4);

        // Locked burst capped at MAX_BURST while M0 waits
        fork
            drive(1, 6, 1'b1, 1'b1, 32'h80, 32'h100, rd1, lg1, lr1, s1, ga1);
            begin
                @(posedge clk); #1;
                drive(0, 1, 1'b0, 1'b0, 32'h80, 32'h0, rd0, lg0, lr0, s0, ga0);
            end
        join
        check("t5_m0_wait", 32'(lg0), 32'd9);
        check("t5_m0_reads_burst_data", rd0, 32'h100);

        // Reset while a read is in its ACCESS cycle
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.m0_gnt && k < 60);
        check("t6_reached_access", {31'd0, bus.m0_gnt}, 32'd1);
        #1 rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_after_reset_ctl", {24'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                                     bus.ram_we, bus.uart_cs, bus.uart_wr, bus.uart_rd}, 32'd0);
        check("t6_after_reset_addr", bus.bus_addr, 32'd0);
        @(posedge clk); #1;
        drive(0, 1, 1'b0, 1'b0, 32'h10, 32'h0, rd0, lg0, lr0, s0, ga0);
        check("t6_recover_gnt", 32'(lg0), 32'd1);
        check("t6_recover_data", rd0, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
